// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: icache address/data, redirect request and the decode handshake.
// The master side is the fetch queue; the slave side is the surrounding pipeline.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          id_ready;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [63:0]   id_pc;
  logic [CW-1:0] count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output id_valid,
    output id_instr,
    output id_pc,
    output count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: walks the fetch PC, captures icache words into a small
// {pc, instr} FIFO and presents the head to decode; a redirect flushes and restarts fetch.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [63:0]   fetch_pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Full is judged on the current occupancy, so a pop never frees a slot for the same cycle's push.
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    push  = !full && !bus.redirect_valid;
    pop   = !empty && bus.id_ready && !bus.redirect_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 64'd1;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: a slot is only read once the occupancy says it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  always_comb begin
    bus.imem_addr = fetch_pc[31:0];
    bus.count     = count_q;
    bus.id_valid  = !empty;
    bus.id_instr  = NOP;
    bus.id_pc     = 64'h0;
    if (!empty) begin
      bus.id_instr = instr_mem[rd_ptr];
      bus.id_pc    = pc_mem[rd_ptr];
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random traffic,
// all compared against a queue-based model of the fetch stream.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // The icache returns 0x100 plus the word address it is given.
  assign bus.imem_rdata = 32'h100 + bus.imem_addr;

  int testCount = 0;
  int failCount = 0;

  // Model: ordered list of fetched PCs still owed to decode, plus the next PC to fetch.
  logic [63:0] refQ[$];
  logic [63:0] refPc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic        hasHead;
    logic [63:0] headPc;
    logic [31:0] headInstr;
    hasHead   = (refQ.size() > 0);
    headPc    = hasHead ? refQ[0] : 64'h0;
    headInstr = hasHead ? (32'h100 + refQ[0][31:0]) : NOP;
    check({tag, ".valid"}, 64'(bus.id_valid), 64'(hasHead));
    check({tag, ".count"}, 64'(bus.count), 64'(refQ.size()));
    check({tag, ".addr"},  64'(bus.imem_addr), 64'(refPc[31:0]));
    check({tag, ".pc"},    bus.id_pc, headPc);
    check({tag, ".instr"}, 64'(bus.id_instr), 64'(headInstr));
  endtask

  // Drive one cycle of inputs, advance the model by one clock, land on the next falling edge.
  task automatic applyStimulus(input logic redir, input logic [63:0] rpc, input logic ready);
    logic wasFull;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.id_ready       = ready;
    wasFull = (refQ.size() == DEPTH);
    if (redir) begin
      refQ.delete();
      refPc = rpc;
    end else begin
      if (refQ.size() > 0 && ready) void'(refQ.pop_front());
      if (!wasFull) begin
        refQ.push_back(refPc);
        refPc = refPc + 64'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
  task automatic doReset(input string tag);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.id_ready       = 1'b0;
    rst = 1'b0;
    #1;
    refQ.delete();
    refPc = RESET_PC;
    checkOutput(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    doReset("por");

    // Streaming with decode always ready: one instruction per cycle, occupancy settles at one.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 64'h0, 1'b1);
      checkOutput("stream");
    end

    // Decode stalled: queue fills to DEPTH and the fetch address freezes.
    doReset("rst2");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 64'h0, 1'b0);
      checkOutput("stall");
    end
    // Single pop out of a full queue, with no push in that cycle.
    applyStimulus(1'b0, 64'h0, 1'b1);
    checkOutput("fullpop");
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkOutput("refill");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 64'h0, 1'b1);
      checkOutput("drain");
    end

    // Redirect with entries queued, followed by fetch from the new target.
    applyStimulus(1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b0);
    checkOutput("prefill");
    applyStimulus(1'b1, 64'h40, 1'b1);
    checkOutput("redir");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 64'h0, 1'b1);
      checkOutput("redir.run");
    end

    // PC wraps past the top of the 64-bit space.
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 64'h0, (i > 1));
      checkOutput("wrap");
    end

    // Back-to-back redirects: only the last target survives.
    applyStimulus(1'b1, 64'h1000, 1'b1);
    applyStimulus(1'b1, 64'h2000, 1'b1);
    checkOutput("b2b");
    applyStimulus(1'b0, 64'h0, 1'b1);
    checkOutput("b2b.run");

    // Mid-stream asynchronous reset with three entries held.
    doReset("rst3");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'h0, 1'b0);
    checkOutput("pre_arst");
    #2;
    doReset("arst");
    applyStimulus(1'b0, 64'h0, 1'b1);
    checkOutput("post_arst");

    // Random traffic, with occasional redirects and asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      logic        redir;
      logic [63:0] rpc;
      redir = ($urandom_range(15) == 0);
      rpc   = ($urandom_range(3) == 0) ? (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(3)))
                                       : {$urandom, $urandom};
      if ($urandom_range(99) == 0) begin
        #2;
        doReset("rnd.arst");
      end
      applyStimulus(redir, rpc, ($urandom_range(2) != 0));
      checkOutput("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end: owns the fetch PC, drives the word address into the instruction cache and captures the returned instruction word.
- Buffers fetched {pc, instr} pairs in a small FIFO and hands them to the decode stage over a valid/ready handshake.
- Decouples decode stalls from fetch and flushes on redirect (branch/jump).
- Sits between the icache and the decode-stage field/immediate extraction.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 64'h0, fetch PC value after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- imem_addr  output  32  word address to icache; equals fetch_pc[31:0].
- imem_rdata  input  32  instruction word at imem_addr; combinational, same cycle.
- redirect_valid  input  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  input  64  new fetch PC (word address).
- id_ready  input  1  decode can accept an instruction this cycle.
- id_valid  output  1  head entry valid.
- id_instr  output  32  head instruction.
- id_pc  output  64  PC of head instruction.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous; also mid-operation):
  - fetch_pc = RESET_PC; wr_ptr = rd_ptr = 0; count = 0.
  - id_valid = 0, id_instr = 32'h00000013, id_pc = 0.
  - Reset clears all in-flight entries immediately.
- PCs are word addresses. Sequential next PC = fetch_pc + 1, wrapping modulo 2^64.
- Internal signals:
  - full = (count == DEPTH); empty = (count == 0).
  - push = !full && !redirect_valid.
  - pop = id_valid && id_ready && !redirect_valid.
- Push: mem[wr_ptr] <= {fetch_pc, imem_rdata}; wr_ptr <= wr_ptr + 1 mod DEPTH; fetch_pc <= fetch_pc + 1.
- No push (full): fetch_pc holds and imem_addr is stable.
- Pop: rd_ptr <= rd_ptr + 1 mod DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- full is evaluated on the current count. A pop in a full cycle does not enable a push that same cycle; the push happens the following cycle. Maximum steady-state throughput is 1 instruction/cycle when DEPTH >= 2 and the queue is not full.
- Outputs (combinational from registered state):
  - id_valid = !empty.
  - When empty: id_instr = 32'h00000013 (NOP), id_pc = 0.
  - When not empty: id_instr and id_pc are the head entry.
  - Head entry stays stable while id_valid && !id_ready.
- Redirect has top priority:
  - Next edge: wr_ptr = rd_ptr = 0, count = 0, fetch_pc = redirect_pc. No push and no pop that cycle.
  - A handshake shown to decode in the redirect cycle is discarded; decode must kill it.
  - First new instruction appears at id_valid one cycle after the redirect edge, with id_pc = redirect_pc.
- Back-to-back redirects: the last one wins; each flushes.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Entry order is preserved across wrap.
- No X propagation: memory contents are only observed when count > 0.

Test Plan:
- Reset then release, icache preloaded with mem[i] = 32'h100+i, id_ready=1 -> id_valid rises on the first edge after release; id_pc = 0,1,2,3... with id_instr = 32'h100,32'h101,... one per cycle, count settles at 1.
- id_ready=0 for 10 cycles after reset, DEPTH=4 -> count goes 1,2,3,4 then holds; imem_addr frozen at 4; raise id_ready -> pcs 0,1,2,3,4,5 in order, no gap or duplicate across pointer wrap.
- Full queue, id_ready=1 for one cycle -> that cycle pops pc 0 with no push, count 4->3; next cycle pushes pc 4.
- Queue holding pcs 5..7, assert redirect_valid with redirect_pc=64'h40 -> next edge count=0, id_valid=0; following edge id_valid=1, id_pc=64'h40, id_instr=mem[64'h40].
- redirect_pc=64'hFFFF_FFFF_FFFF_FFFF -> the next entries have id_pc = 64'hFFFF_FFFF_FFFF_FFFF then 64'h0.
- Assert rst low asynchronously mid-stream with count=3 -> outputs clear immediately without a clock edge (id_valid=0, count=0, id_instr=32'h00000013); after release fetch restarts at RESET_PC.
